// File: rtl/pck_injct_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : pck_injct_traffic_gen
// Purpose  : Per-endpoint packet request generator for a packet injector.
//            It issues one-cycle packet requests (pck_wr with size, data,
//            destination and VC), inserts programmable gaps between them,
//            and counts packets/flits sent and received.
// Ports    : clk, reset (sync, active high)
//            start/stop, pck_num_limit, inject_gap   run control
//            dest_mode, fixed_dest, self_id, vc_in   request shaping
//            ready                                    per-VC injector ready
//            pck_wr, pck_size, pck_data,
//            pck_dest_id, pck_vc                      request outputs
//            rx_pck_wr, rx_size                       delivered packets
//            sent_/rcvd_ pck/flit counters, busy, done
// Revision : 1.0 - initial release
// ============================================================================
module pck_injct_traffic_gen #(
    parameter int          NE           = 16,
    parameter int          NEw          = 4,
    parameter int          V            = 2,
    parameter int          SIZEw        = 5,
    parameter int          DATAw        = 128,
    parameter int          PCK_SIZE_MIN = 3,
    parameter int          PCK_SIZE_MAX = 20,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [31:0]      pck_num_limit,
    input  logic [7:0]       inject_gap,
    input  logic [1:0]       dest_mode,
    input  logic [NEw-1:0]   fixed_dest,
    input  logic [NEw-1:0]   self_id,
    input  logic [V-1:0]     vc_in,
    input  logic [V-1:0]     ready,
    output logic             pck_wr,
    output logic [SIZEw-1:0] pck_size,
    output logic [DATAw-1:0] pck_data,
    output logic [NEw-1:0]   pck_dest_id,
    output logic [V-1:0]     pck_vc,
    input  logic             rx_pck_wr,
    input  logic [SIZEw-1:0] rx_size,
    output logic [31:0]      sent_pck_cnt,
    output logic [31:0]      sent_flit_cnt,
    output logic [31:0]      rcvd_pck_cnt,
    output logic [31:0]      rcvd_flit_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_RDY = 3'd1;
    localparam logic [2:0] c_ST_ISSUE    = 3'd2;
    localparam logic [2:0] c_ST_GAP      = 3'd3;
    localparam logic [2:0] c_ST_DONE     = 3'd4;

    localparam logic [SIZEw-1:0] c_SIZE_MIN = SIZEw'(PCK_SIZE_MIN);
    localparam logic [SIZEw-1:0] c_SIZE_MAX = SIZEw'(PCK_SIZE_MAX);
    localparam logic [NEw:0]     c_NE_EXT   = (NEw+1)'(NE);
    localparam logic [NEw:0]     c_NE_LAST  = (NEw+1)'(NE - 1);

    logic [2:0]       r_state, w_next_state;
    logic             r_pck_wr, r_busy, r_done;
    logic [SIZEw-1:0] r_pck_size;
    logic [DATAw-1:0] r_pck_data;
    logic [NEw-1:0]   r_pck_dest;
    logic [V-1:0]     r_pck_vc;
    logic [31:0]      r_sent_pck, r_sent_flit, r_rcvd_pck, r_rcvd_flit;
    logic [15:0]      r_lfsr;
    logic [SIZEw-1:0] r_size_cnt;
    logic [NEw-1:0]   r_rr_dest;
    logic [7:0]       r_gap_cnt;

    logic             w_start_ok, w_rdy, w_last, w_lfsr_fb;
    logic [NEw-1:0]   w_rr_used, w_rnd_raw, w_rnd, w_dest;
    logic [DATAw-1:0] w_data;

    function automatic logic [31:0] f_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [NEw-1:0] f_inc_mod(input logic [NEw-1:0] x);
        return ({1'b0, x} == c_NE_LAST) ? '0 : x + 1'b1;
    endfunction

    assign w_start_ok = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_rdy      = |(ready & vc_in);
    // Compared in 33 bits so a saturated packet counter cannot wrap past the limit.
    assign w_last     = (({1'b0, r_sent_pck} + 33'd1) >= {1'b0, pck_num_limit});
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Destination select. Round-robin substitutes self_id with the next id so
    // an endpoint never targets itself; the pointer then advances past the used id.
    always_comb begin
        w_rr_used = (r_rr_dest == self_id) ? f_inc_mod(self_id) : r_rr_dest;
        w_rnd_raw = r_lfsr[NEw-1:0];
        w_rnd     = ({1'b0, w_rnd_raw} >= c_NE_EXT) ? (w_rnd_raw - c_NE_EXT[NEw-1:0]) : w_rnd_raw;
        case (dest_mode)
            2'd1:    w_dest = w_rr_used;
            2'd2:    w_dest = w_rnd;
            default: w_dest = fixed_dest;
        endcase
    end

    always_comb begin
        w_data           = '0;
        w_data[31:0]     = r_sent_pck;
        w_data[32 +: NEw] = self_id;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (start)
                    w_next_state = (pck_num_limit == 32'd0) ? c_ST_DONE : c_ST_WAIT_RDY;
            end
            c_ST_WAIT_RDY: begin
                if (stop)       w_next_state = c_ST_DONE;
                else if (w_rdy) w_next_state = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                if (w_last || stop)           w_next_state = c_ST_DONE;
                else if (inject_gap == 8'd0)  w_next_state = c_ST_WAIT_RDY;
                else                          w_next_state = c_ST_GAP;
            end
            c_ST_GAP: begin
                if (stop)                   w_next_state = c_ST_DONE;
                else if (r_gap_cnt <= 8'd1) w_next_state = c_ST_WAIT_RDY;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Registered outputs, counters and generator state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pck_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pck_size  <= '0;
            r_pck_data  <= '0;
            r_pck_dest  <= '0;
            r_pck_vc    <= '0;
            r_sent_pck  <= '0;
            r_sent_flit <= '0;
            r_rcvd_pck  <= '0;
            r_rcvd_flit <= '0;
            r_lfsr      <= LFSR_SEED;
            r_size_cnt  <= c_SIZE_MIN;
            r_rr_dest   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_pck_wr <= (w_next_state == c_ST_ISSUE);
            r_busy   <= (w_next_state == c_ST_WAIT_RDY) || (w_next_state == c_ST_ISSUE) ||
                        (w_next_state == c_ST_GAP);
            r_done   <= (w_next_state == c_ST_DONE);

            if (w_start_ok) begin
                r_sent_pck  <= '0;
                r_sent_flit <= '0;
                r_lfsr      <= LFSR_SEED;
                r_size_cnt  <= c_SIZE_MIN;
                r_rr_dest   <= '0;
            end

            // Request fields are captured on entry to ISSUE so they are valid
            // exactly while pck_wr is high.
            if ((r_state == c_ST_WAIT_RDY) && (w_next_state == c_ST_ISSUE)) begin
                r_pck_size <= r_size_cnt;
                r_pck_data <= w_data;
                r_pck_dest <= w_dest;
                r_pck_vc   <= vc_in;
            end

            if (r_state == c_ST_ISSUE) begin
                r_sent_pck  <= f_sat_add(r_sent_pck, 32'd1);
                r_sent_flit <= f_sat_add(r_sent_flit, 32'(r_pck_size));
                r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
                r_size_cnt  <= (r_size_cnt == c_SIZE_MAX) ? c_SIZE_MIN : r_size_cnt + 1'b1;
                r_rr_dest   <= f_inc_mod(w_rr_used);
                if (w_next_state == c_ST_GAP)
                    r_gap_cnt <= inject_gap;
            end else if ((r_state == c_ST_GAP) && (r_gap_cnt != 8'd0)) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end

            // A start clears the receive counters before the same-edge rx event counts.
            if (w_start_ok) begin
                r_rcvd_pck  <= rx_pck_wr ? 32'd1 : 32'd0;
                r_rcvd_flit <= rx_pck_wr ? 32'(rx_size) : 32'd0;
            end else if (rx_pck_wr) begin
                r_rcvd_pck  <= f_sat_add(r_rcvd_pck, 32'd1);
                r_rcvd_flit <= f_sat_add(r_rcvd_flit, 32'(rx_size));
            end
        end
    end

    assign pck_wr        = r_pck_wr;
    assign pck_size      = r_pck_size;
    assign pck_data      = r_pck_data;
    assign pck_dest_id   = r_pck_dest;
    assign pck_vc        = r_pck_vc;
    assign sent_pck_cnt  = r_sent_pck;
    assign sent_flit_cnt = r_sent_flit;
    assign rcvd_pck_cnt  = r_rcvd_pck;
    assign rcvd_flit_cnt = r_rcvd_flit;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pck_injct_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pck_injct_traffic_gen
// Purpose  : Directed self-checking bench for pck_injct_traffic_gen.
//            Inputs change on the falling edge; a monitor logs every pck_wr
//            strobe shortly after the rising edge with its cycle number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pck_injct_traffic_gen;

    localparam int NE = 16, NEw = 4, V = 2, SIZEw = 5, DATAw = 128;

    logic             clk = 1'b0;
    logic             reset, start, stop;
    logic [31:0]      pck_num_limit;
    logic [7:0]       inject_gap;
    logic [1:0]       dest_mode;
    logic [NEw-1:0]   fixed_dest, self_id;
    logic [V-1:0]     vc_in, ready;
    logic             pck_wr;
    logic [SIZEw-1:0] pck_size;
    logic [DATAw-1:0] pck_data;
    logic [NEw-1:0]   pck_dest_id;
    logic [V-1:0]     pck_vc;
    logic             rx_pck_wr;
    logic [SIZEw-1:0] rx_size;
    logic [31:0]      sent_pck_cnt, sent_flit_cnt, rcvd_pck_cnt, rcvd_flit_cnt;
    logic             busy, done;

    always #5 clk = ~clk;

    pck_injct_traffic_gen dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .pck_num_limit(pck_num_limit), .inject_gap(inject_gap),
        .dest_mode(dest_mode), .fixed_dest(fixed_dest), .self_id(self_id),
        .vc_in(vc_in), .ready(ready),
        .pck_wr(pck_wr), .pck_size(pck_size), .pck_data(pck_data),
        .pck_dest_id(pck_dest_id), .pck_vc(pck_vc),
        .rx_pck_wr(rx_pck_wr), .rx_size(rx_size),
        .sent_pck_cnt(sent_pck_cnt), .sent_flit_cnt(sent_flit_cnt),
        .rcvd_pck_cnt(rcvd_pck_cnt), .rcvd_flit_cnt(rcvd_flit_cnt),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [SIZEw-1:0] q_size[$];
    logic [DATAw-1:0] q_data[$];
    logic [NEw-1:0]   q_dest[$];
    logic [V-1:0]     q_vc[$];
    int               q_cyc[$];
    logic [NEw-1:0]   rnd_ref[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (pck_wr) begin
            q_size.push_back(pck_size);
            q_data.push_back(pck_data);
            q_dest.push_back(pck_dest_id);
            q_vc.push_back(pck_vc);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_size.delete(); q_data.delete(); q_dest.delete(); q_vc.delete(); q_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfg(input int limit, input int gap, input int mode, input int fixd, input int self);
        pck_num_limit = 32'(limit);
        inject_gap    = 8'(gap);
        dest_mode     = 2'(mode);
        fixed_dest    = NEw'(fixd);
        self_id       = NEw'(self);
    endtask

    task automatic start_run();
        clear_q();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && !done; k++) @(negedge clk);
        check_val(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic wait_pkts(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && (q_size.size() < n); k++) @(negedge clk);
        check_val(tag, {63'd0, q_size.size() >= n}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b0; start = 1'b0; stop = 1'b0; rx_pck_wr = 1'b0; rx_size = '0;
        vc_in = 2'b01; ready = 2'b11;
        cfg(0, 0, 0, 0, 0);

        // ---- reset state ----
        do_reset();
        check_val("rst_flags", {61'd0, pck_wr, busy, done}, 64'd0);
        check_val("rst_sent", {sent_pck_cnt, sent_flit_cnt}, 64'd0);
        check_val("rst_rcvd", {rcvd_pck_cnt, rcvd_flit_cnt}, 64'd0);

        // ---- basic run: 3 packets, fixed dest 5 ----
        cfg(3, 0, 0, 5, 2);
        start_run();
        wait_done("basic_done", 50);
        check_val("basic_npk", 64'(q_size.size()), 64'd3);
        check_val("basic_sizes", {q_size[0], q_size[1], q_size[2]}, {5'd3, 5'd4, 5'd5});
        check_val("basic_seq", {q_data[1][31:0], q_data[2][31:0]}, {32'd1, 32'd2});
        check_val("basic_data0", q_data[0][63:0], 64'h0000_0002_0000_0000);
        check_val("basic_data_hi", q_data[0][127:64], 64'd0);
        check_val("basic_dest", {q_dest[0], q_dest[1], q_dest[2]}, {4'd5, 4'd5, 4'd5});
        check_val("basic_vc", 64'(q_vc[0]), 64'd1);
        check_val("basic_spacing", 64'(q_cyc[1] - q_cyc[0]), 64'd2);
        check_val("basic_sent", {sent_pck_cnt, sent_flit_cnt}, {32'd3, 32'd12});
        check_val("basic_busy", {63'd0, busy}, 64'd0);

        // ---- backpressure: ready only on a VC not selected ----
        cfg(2, 0, 0, 5, 2);
        ready = 2'b10;
        start_run();
        repeat (20) @(negedge clk);
        check_val("bp_none", 64'(q_size.size()), 64'd0);
        check_val("bp_busy", {63'd0, busy}, 64'd1);
        ready = 2'b11;
        wait_done("bp_done", 50);
        check_val("bp_sent", {sent_pck_cnt, sent_flit_cnt}, {32'd2, 32'd7});

        // ---- ready dropped mid-run ----
        cfg(5, 1, 0, 5, 2);
        ready = 2'b01;
        start_run();
        wait_pkts("mid_first", 1, 50);
        ready = 2'b00;
        repeat (10) @(negedge clk);
        check_val("mid_hold", 64'(q_size.size()), 64'd1);
        ready = 2'b01;
        wait_done("mid_done", 100);
        check_val("mid_npk", 64'(q_size.size()), 64'd5);
        check_val("mid_sent", {sent_pck_cnt, sent_flit_cnt}, {32'd5, 32'd25});

        // ---- gap 4 and size wrap ----
        cfg(20, 4, 0, 7, 2);
        start_run();
        wait_done("gap_done", 300);
        check_val("gap_npk", 64'(q_size.size()), 64'd20);
        bad = 0;
        for (int i = 1; i < q_cyc.size(); i++) if (q_cyc[i] - q_cyc[i-1] != 6) bad++;
        check_val("gap_spacing", 64'(bad), 64'd0);
        if (q_size.size() == 20) begin
            check_val("gap_size_wrap", {q_size[0], q_size[17], q_size[18], q_size[19]},
                      {5'd3, 5'd20, 5'd3, 5'd4});
            check_val("gap_seq_last", 64'(q_data[19][31:0]), 64'd19);
        end
        check_val("gap_flits", 64'(sent_flit_cnt), 64'd214);

        // ---- round-robin, self 0 ----
        cfg(17, 0, 1, 0, 0);
        start_run();
        wait_done("rr_done", 100);
        check_val("rr_npk", 64'(q_dest.size()), 64'd17);
        bad = 0;
        for (int i = 0; i < q_dest.size(); i++)
            if (q_dest[i] != NEw'((i < 15) ? i + 1 : i - 14)) bad++;
        check_val("rr_seq", 64'(bad), 64'd0);

        // ---- random mode, reproducible after reset ----
        cfg(8, 0, 2, 0, 3);
        start_run();
        wait_done("rnd_done", 100);
        check_val("rnd_npk", 64'(q_dest.size()), 64'd8);
        check_val("rnd_first", 64'(q_dest[0]), 64'd1);
        rnd_ref = q_dest;
        bad = 0;
        for (int i = 0; i < q_dest.size(); i++) if (32'(q_dest[i]) >= NE) bad++;
        check_val("rnd_range", 64'(bad), 64'd0);
        do_reset();
        start_run();
        wait_done("rnd2_done", 100);
        bad = 0;
        for (int i = 0; i < rnd_ref.size(); i++)
            if (i >= q_dest.size() || q_dest[i] != rnd_ref[i]) bad++;
        check_val("rnd_repro", 64'(bad), 64'd0);

        // ---- stop during GAP ----
        cfg(10, 5, 0, 4, 2);
        start_run();
        wait_pkts("stopg_first", 1, 50);
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("stopg_done", {62'd0, busy, done}, 64'd1);
        repeat (20) @(negedge clk);
        check_val("stopg_npk", {32'(q_size.size()), sent_pck_cnt}, {32'd1, 32'd1});

        // ---- stop during ISSUE completes the packet ----
        cfg(10, 0, 0, 4, 2);
        start_run();
        wait_pkts("stopi_first", 1, 50);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_val("stopi_state", {62'd0, busy, done}, 64'd1);
        check_val("stopi_sent", {sent_pck_cnt, sent_flit_cnt}, {32'd1, 32'd3});

        // ---- reset during ISSUE ----
        cfg(5, 0, 0, 4, 2);
        start_run();
        wait_pkts("rsti_first", 1, 50);
        reset = 1'b1;
        @(negedge clk);
        check_val("rsti_wr", {62'd0, pck_wr, busy}, 64'd0);
        check_val("rsti_cnt", {sent_pck_cnt, sent_flit_cnt}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---- receive side ----
        rx_pck_wr = 1'b1; rx_size = 5'd3;
        @(negedge clk);
        rx_size = 5'd7;
        @(negedge clk);
        rx_pck_wr = 1'b0;
        @(negedge clk);
        check_val("rx_cnt", {rcvd_pck_cnt, rcvd_flit_cnt}, {32'd2, 32'd10});
        cfg(0, 0, 0, 4, 2);
        start = 1'b1; rx_pck_wr = 1'b1; rx_size = 5'd9;
        @(negedge clk);
        start = 1'b0; rx_pck_wr = 1'b0;
        check_val("rx_start", {rcvd_pck_cnt, rcvd_flit_cnt}, {32'd1, 32'd9});
        check_val("rx_start_done", {62'd0, busy, done}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
